// File: rtl/vend_ctrl_param_if.sv
// Coin/refund handshake bundle for vend_ctrl_param.
// The controller takes the slave side and the coin acceptor/dispenser takes the master side.
interface vend_ctrl_param_if #(
    parameter int CREDIT_W = 4
);
    logic                coin_valid;
    logic [1:0]          coin_type;
    logic                cancel;
    logic                change_ack;
    logic [CREDIT_W-1:0] credit;
    logic                vend;
    logic                coin_reject;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amt;

    modport master (
        output coin_valid, coin_type, cancel, change_ack,
        input  credit, vend, coin_reject, change_valid, change_amt
    );

    modport slave (
        input  coin_valid, coin_type, cancel, change_ack,
        output credit, vend, coin_reject, change_valid, change_amt
    );
endinterface

// File: rtl/vend_ctrl_param.sv
// Parameterised vending controller: accumulates coins, vends at PRICE, and refunds or returns change.
// The change/refund path is enabled only when the VEND_CHANGE_RETURN_EN macro is defined.
module vend_ctrl_param #(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 10,
    parameter int CREDIT_W   = 4
) (
    input logic              clk,
    input logic              rstn,
    vend_ctrl_param_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(MAX_CREDIT);

    state_t              state;
    logic [CREDIT_W-1:0] credit;
    logic                vend;
    logic                coin_reject;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] sum;
    logic                coin_ok;

    always_comb begin
        coin_val = '0;
        case (bus.coin_type)
            2'b01:   coin_val = CREDIT_W'(1);
            2'b10:   coin_val = CREDIT_W'(2);
            2'b11:   coin_val = CREDIT_W'(5);
            default: coin_val = '0;
        endcase
    end

    // CREDIT_W leaves headroom for MAX_CREDIT+5, so the sum cannot wrap.
    assign sum     = credit + coin_val;
    assign coin_ok = (coin_val != '0) && (sum <= MAX_C);

`ifdef VEND_CHANGE_RETURN_EN
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amt;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            credit      <= '0;
            vend        <= 1'b0;
            coin_reject <= 1'b0;
`ifdef VEND_CHANGE_RETURN_EN
            change_valid <= 1'b0;
            change_amt   <= '0;
`endif
        end else begin
            vend        <= 1'b0;
            coin_reject <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    // A simultaneous coin loses to cancel and is handed back.
                    if (bus.cancel) begin
                        coin_reject <= bus.coin_valid;
                        if (state == COLLECT) begin
                            credit <= '0;
`ifdef VEND_CHANGE_RETURN_EN
                            state        <= CHANGE;
                            change_valid <= 1'b1;
                            change_amt   <= credit;
`else
                            state <= IDLE;
`endif
                        end
                    end else if (bus.coin_valid) begin
                        if (coin_ok) begin
                            credit <= sum;
                            if (sum >= PRICE_C) begin
                                state <= VEND;
                                vend  <= 1'b1;
                            end else begin
                                state <= COLLECT;
                            end
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    coin_reject <= bus.coin_valid;
                    credit      <= '0;
`ifdef VEND_CHANGE_RETURN_EN
                    if (credit > PRICE_C) begin
                        state        <= CHANGE;
                        change_valid <= 1'b1;
                        change_amt   <= credit - PRICE_C;
                    end else begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
`ifdef VEND_CHANGE_RETURN_EN
                CHANGE: begin
                    coin_reject <= bus.coin_valid;
                    if (bus.change_ack) begin
                        state        <= IDLE;
                        change_valid <= 1'b0;
                        change_amt   <= '0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.credit      = credit;
    assign bus.vend        = vend;
    assign bus.coin_reject = coin_reject;
`ifdef VEND_CHANGE_RETURN_EN
    assign bus.change_valid = change_valid;
    assign bus.change_amt   = change_amt;
`else
    logic unused_change_ack;
    assign unused_change_ack = bus.change_ack;
    assign bus.change_valid  = 1'b0;
    assign bus.change_amt    = '0;
`endif
endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param: two instances (PRICE=3 and PRICE=10) share stimulus and are
// checked every cycle against a credit/owed-change model, plus literal checks on key sequences.
module tb_vend_ctrl_param;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'b00;
    logic       cancel = 1'b0;
    logic       change_ack = 1'b0;

    always #5 clk = ~clk;

    vend_ctrl_param_if #(.CREDIT_W(4)) bus_a ();
    vend_ctrl_param_if #(.CREDIT_W(4)) bus_b ();

    assign bus_a.coin_valid = coin_valid;
    assign bus_a.coin_type  = coin_type;
    assign bus_a.cancel     = cancel;
    assign bus_a.change_ack = change_ack;
    assign bus_b.coin_valid = coin_valid;
    assign bus_b.coin_type  = coin_type;
    assign bus_b.cancel     = cancel;
    assign bus_b.change_ack = change_ack;

    vend_ctrl_param #(.PRICE(3), .MAX_CREDIT(10), .CREDIT_W(4)) dut_a (
        .clk(clk), .rstn(rstn), .bus(bus_a));
    vend_ctrl_param #(.PRICE(10), .MAX_CREDIT(10), .CREDIT_W(4)) dut_b (
        .clk(clk), .rstn(rstn), .bus(bus_b));

    typedef struct {
        int credit;
        bit vend;
        bit rej;
        bit cv;
        int amt;
    } mdl_t;

    mdl_t ma, mb;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    // Outputs expected after one clock, reasoning only about credit held and change owed.
    function automatic mdl_t model_step(mdl_t m, int price, int max_c, bit rn,
                                        bit cvld, logic [1:0] ct, bit cnl, bit ack);
        mdl_t n;
        int   v;
        n      = m;
        n.vend = 1'b0;
        n.rej  = 1'b0;
        if (!rn) begin
            n = '{0, 1'b0, 1'b0, 1'b0, 0};
            return n;
        end
        v = (ct == 2'b01) ? 1 : (ct == 2'b10) ? 2 : (ct == 2'b11) ? 5 : 0;
        if (m.vend) begin
            n.rej    = cvld;
            n.credit = 0;
`ifdef VEND_CHANGE_RETURN_EN
            n.amt = m.credit - price;
            n.cv  = (n.amt > 0);
`endif
        end else if (m.cv) begin
            n.rej = cvld;
            if (ack) begin
                n.cv  = 1'b0;
                n.amt = 0;
            end
        end else if (cnl) begin
            n.rej = cvld;
`ifdef VEND_CHANGE_RETURN_EN
            if (m.credit > 0) begin
                n.cv  = 1'b1;
                n.amt = m.credit;
            end
`endif
            n.credit = 0;
        end else if (cvld) begin
            if (v == 0 || m.credit + v > max_c) n.rej = 1'b1;
            else begin
                n.credit = m.credit + v;
                n.vend   = (n.credit >= price);
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_credit", 32'(bus_a.credit), 32'(ma.credit));
            chk("a_vend", 32'(bus_a.vend), 32'(ma.vend));
            chk("a_reject", 32'(bus_a.coin_reject), 32'(ma.rej));
            chk("a_change_valid", 32'(bus_a.change_valid), 32'(ma.cv));
            chk("a_change_amt", 32'(bus_a.change_amt), 32'(ma.amt));
            chk("a_vend_and_change", 32'(bus_a.vend & bus_a.change_valid), 32'd0);
            chk("b_credit", 32'(bus_b.credit), 32'(mb.credit));
            chk("b_vend", 32'(bus_b.vend), 32'(mb.vend));
            chk("b_reject", 32'(bus_b.coin_reject), 32'(mb.rej));
            chk("b_change_valid", 32'(bus_b.change_valid), 32'(mb.cv));
            chk("b_change_amt", 32'(bus_b.change_amt), 32'(mb.amt));
            chk("b_vend_and_change", 32'(bus_b.vend & bus_b.change_valid), 32'd0);
        end
    end

    // Inputs are set just after a rising edge; models advance just after the mid-cycle compare.
    task automatic drive(input bit cv, input logic [1:0] ct, input bit cn, input bit ak);
        coin_valid = cv;
        coin_type  = ct;
        cancel     = cn;
        change_ack = ak;
        @(negedge clk);
        #1;
        ma = model_step(ma, 3, 10, rstn, cv, ct, cn, ak);
        mb = model_step(mb, 10, 10, rstn, cv, ct, cn, ak);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        rstn = 1'b1;
    endtask

    initial begin
        ma = '{0, 1'b0, 1'b0, 1'b0, 0};
        mb = '{0, 1'b0, 1'b0, 1'b0, 0};
        do_reset();
        chk_en = 1'b1;
        chk("rst_credit", 32'(bus_a.credit), 32'd0);
        chk("rst_vend", 32'(bus_a.vend), 32'd0);
        chk("rst_reject", 32'(bus_a.coin_reject), 32'd0);
        chk("rst_change_valid", 32'(bus_a.change_valid), 32'd0);
        chk("rst_change_amt", 32'(bus_a.change_amt), 32'd0);

        // Exact price from two coins.
        drive(1'b1, 2'b01, 1'b0, 1'b0);
        chk("exact_credit1", 32'(bus_a.credit), 32'd1);
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        chk("exact_credit3", 32'(bus_a.credit), 32'd3);
        chk("exact_vend", 32'(bus_a.vend), 32'd1);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        chk("exact_idle_credit", 32'(bus_a.credit), 32'd0);
        chk("exact_no_change", 32'(bus_a.change_valid), 32'd0);

        // Overpay with a quarter, change held for four cycles.
        do_reset();
        drive(1'b1, 2'b11, 1'b0, 1'b0);
        chk("over_vend", 32'(bus_a.vend), 32'd1);
        chk("over_credit", 32'(bus_a.credit), 32'd5);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        chk("over_credit_clr", 32'(bus_a.credit), 32'd0);
        chk("over_vend_off", 32'(bus_a.vend), 32'd0);
`ifdef VEND_CHANGE_RETURN_EN
        chk("over_cv", 32'(bus_a.change_valid), 32'd1);
        chk("over_amt", 32'(bus_a.change_amt), 32'd2);
        repeat (3) drive(1'b0, 2'b00, 1'b0, 1'b0);
        chk("over_cv_held", 32'(bus_a.change_valid), 32'd1);
        chk("over_amt_held", 32'(bus_a.change_amt), 32'd2);
`else
        chk("over_cv_off", 32'(bus_a.change_valid), 32'd0);
        repeat (3) drive(1'b0, 2'b00, 1'b0, 1'b0);
`endif
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        chk("over_ack_cv", 32'(bus_a.change_valid), 32'd0);
        chk("over_ack_amt", 32'(bus_a.change_amt), 32'd0);

        // Credit ceiling on the PRICE=10 instance.
        do_reset();
        drive(1'b1, 2'b11, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        chk("max_credit9", 32'(bus_b.credit), 32'd9);
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        chk("max_reject", 32'(bus_b.coin_reject), 32'd1);
        chk("max_credit_held", 32'(bus_b.credit), 32'd9);
        drive(1'b1, 2'b01, 1'b0, 1'b0);
        chk("max_vend", 32'(bus_b.vend), 32'd1);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        chk("max_no_change", 32'(bus_b.change_valid), 32'd0);
        chk("max_credit_clr", 32'(bus_b.credit), 32'd0);

        // Cancel beats a simultaneous coin.
        do_reset();
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        chk("cancel_credit2", 32'(bus_a.credit), 32'd2);
        drive(1'b1, 2'b01, 1'b1, 1'b0);
        chk("cancel_reject", 32'(bus_a.coin_reject), 32'd1);
        chk("cancel_no_vend", 32'(bus_a.vend), 32'd0);
        chk("cancel_credit0", 32'(bus_a.credit), 32'd0);
`ifdef VEND_CHANGE_RETURN_EN
        chk("cancel_cv", 32'(bus_a.change_valid), 32'd1);
        chk("cancel_amt", 32'(bus_a.change_amt), 32'd2);
`else
        chk("cancel_cv_off", 32'(bus_a.change_valid), 32'd0);
        chk("cancel_amt_off", 32'(bus_a.change_amt), 32'd0);
`endif

        // Reset while change is pending, with busy inputs during the reset cycle.
        do_reset();
        drive(1'b1, 2'b11, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
`ifdef VEND_CHANGE_RETURN_EN
        chk("rstchg_amt_pre", 32'(bus_a.change_amt), 32'd2);
`endif
        rstn = 1'b0;
        drive(1'b1, 2'b01, 1'b1, 1'b1);
        chk("rstchg_cv", 32'(bus_a.change_valid), 32'd0);
        chk("rstchg_amt", 32'(bus_a.change_amt), 32'd0);
        chk("rstchg_credit", 32'(bus_a.credit), 32'd0);
        chk("rstchg_reject", 32'(bus_a.coin_reject), 32'd0);
        rstn = 1'b1;
        drive(1'b1, 2'b01, 1'b0, 1'b0);
        chk("rstchg_credit1", 32'(bus_a.credit), 32'd1);

        // Random traffic against the models.
        repeat (3000) begin
            rstn = ($urandom_range(0, 99) != 0);
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
        end
        rstn = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
